// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer.
// Stage indices, FSM state type and flush counter width.
package pipe_ctrl_pkg;

  localparam int STAGE_IF  = 0;
  localparam int STAGE_ID  = 1;
  localparam int STAGE_EX  = 2;
  localparam int STAGE_MEM = 3;

  localparam int FLUSH_CNT_W = 4;

  typedef enum logic {
    RUN,
    FLUSH
  } pipe_ctrl_state_t;

endpackage

// File: rtl/pipe_ctrl_prio.sv
// stall_prio_enc: picks the deepest stalling stage, one-hot.
// Priority MEM > EX > ID > IF; purely combinational.
module stall_prio_enc
  import pipe_ctrl_pkg::*;
(
  input  logic [3:0] req,
  output logic [3:0] hot
);

  always_comb begin
    hot = '0;
    if (req[STAGE_MEM])
      hot[STAGE_MEM] = 1'b1;
    else if (req[STAGE_EX])
      hot[STAGE_EX] = 1'b1;
    else if (req[STAGE_ID])
      hot[STAGE_ID] = 1'b1;
    else if (req[STAGE_IF])
      hot[STAGE_IF] = 1'b1;
  end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush sequencer for the 5-stage pipeline.
// PIPE_CTRL_PERF_EN adds stall and redirect performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_if,
  input  logic              stallreq_id,
  input  logic              stallreq_ex,
  input  logic              stallreq_mem,
  input  logic              excp_req,
  input  logic [ADDR_W-1:0] excp_target,
  output logic              excp_ack,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              en_pc,
  output logic              en_if_id,
  output logic              en_id_ex,
  output logic              en_ex_mem,
  output logic              en_mem_wb,
  output logic              bub_if_id,
  output logic              bub_id_ex,
  output logic              bub_ex_mem,
  output logic              bub_mem_wb,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
);

  localparam logic [FLUSH_CNT_W-1:0] FLUSH_INIT =
    FLUSH_CNT_W'(FLUSH_CYCLES);

  pipe_ctrl_state_t       state_q, state_d;
  logic [FLUSH_CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]             req, hot;

  assign req = {stallreq_mem, stallreq_ex,
                stallreq_id, stallreq_if};

  stall_prio_enc u_enc (
    .req (req),
    .hot (hot)
  );

  // Outputs fall back to reset values while rst is high.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    excp_ack   = 1'b0;
    en_pc      = 1'b1;
    en_if_id   = 1'b1;
    en_id_ex   = 1'b1;
    en_ex_mem  = 1'b1;
    en_mem_wb  = 1'b1;
    bub_if_id  = 1'b0;
    bub_id_ex  = 1'b0;
    bub_ex_mem = 1'b0;
    bub_mem_wb = 1'b0;
    if (!rst) begin
      unique case (state_q)
        RUN: begin
          if (excp_req && !stallreq_mem) begin
            excp_ack   = 1'b1;
            bub_if_id  = 1'b1;
            bub_id_ex  = 1'b1;
            bub_ex_mem = 1'b1;
            bub_mem_wb = 1'b1;
            state_d    = FLUSH;
            cnt_d      = FLUSH_INIT;
          end else begin
            en_pc      = ~|hot;
            en_if_id   = ~|hot[3:1];
            en_id_ex   = ~|hot[3:2];
            en_ex_mem  = ~hot[3];
            bub_if_id  = hot[0];
            bub_id_ex  = hot[1];
            bub_ex_mem = hot[2];
            bub_mem_wb = hot[3];
          end
        end
        FLUSH: begin
          bub_if_id  = 1'b1;
          bub_id_ex  = 1'b1;
          bub_ex_mem = 1'b1;
          cnt_d      = cnt_q - 4'd1;
          if (cnt_q == 4'd1)
            state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= RUN;
      cnt_q          <= '0;
      redirect_pc    <= '0;
      redirect_valid <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      redirect_valid <= excp_ack;
      if (excp_ack)
        redirect_pc <= excp_target;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (state_q == RUN && |req)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (excp_ack)
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed scenarios plus random traffic
// checked every cycle against a behavioural model.
module tb_pipe_ctrl;

  localparam int FC = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_if = 0, s_id = 0, s_ex = 0, s_mem = 0;
  logic        excp_req = 0;
  logic [31:0] excp_target = '0;
  logic        excp_ack, redirect_valid;
  logic [31:0] redirect_pc;
  logic        en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
  logic        bub_if_id, bub_id_ex, bub_ex_mem, bub_mem_wb;
  logic [31:0] perf_stall_cnt, perf_flush_cnt;

  int vec_n = 0;
  int err_n = 0;

  // model state
  int          busy;
  logic        first;
  logic [31:0] m_pc;
  logic [31:0] m_stall, m_flush;

  // last sampled DUT output vector
  logic [10:0] got;

  always #5 clk = ~clk;

  pipe_ctrl #(.FLUSH_CYCLES(FC), .ADDR_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .stallreq_if    (s_if),
    .stallreq_id    (s_id),
    .stallreq_ex    (s_ex),
    .stallreq_mem   (s_mem),
    .excp_req       (excp_req),
    .excp_target    (excp_target),
    .excp_ack       (excp_ack),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .en_pc          (en_pc),
    .en_if_id       (en_if_id),
    .en_id_ex       (en_id_ex),
    .en_ex_mem      (en_ex_mem),
    .en_mem_wb      (en_mem_wb),
    .bub_if_id      (bub_if_id),
    .bub_id_ex      (bub_id_ex),
    .bub_ex_mem     (bub_ex_mem),
    .bub_mem_wb     (bub_mem_wb),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );

  function automatic logic [10:0] dut_vec();
    return {excp_ack, redirect_valid,
            en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
            bub_if_id, bub_id_ex, bub_ex_mem, bub_mem_wb};
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vec_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    busy    = 0;
    first   = 0;
    m_pc    = '0;
    m_stall = '0;
    m_flush = '0;
  endtask

  // One cycle: drive at negedge, compare 1ns later, advance model at posedge.
  task automatic step(input logic r, input logic si, input logic sd,
                      input logic se, input logic sm, input logic rq,
                      input logic [31:0] tg);
    logic [4:0]  en;
    logic [4:0]  bub;
    logic [3:0]  st;
    logic        acc;
    logic        rv;
    logic [10:0] exp;
    logic [31:0] ps, pf;
    int          k;
    @(negedge clk);
    rst = r; s_if = si; s_id = sd; s_ex = se; s_mem = sm;
    excp_req = rq; excp_target = tg;
    #1;
    if (r) model_reset();
    st  = {sm, se, sd, si};
    en  = '1;
    bub = '0;
    acc = 1'b0;
    rv  = 1'b0;
    if (!r) begin
      if (busy > 0) begin
        bub[3:1] = 3'b111;
        rv = first;
      end else if (rq && !sm) begin
        acc = 1'b1;
        bub[4:1] = 4'b1111;
      end else begin
        k = -1;
        for (int s = 0; s < 4; s++)
          if (st[s]) k = s;
        for (int g = 0; g < 5; g++) begin
          en[g]  = !(g <= k);
          bub[g] = (g == k + 1) && (g > 0);
        end
      end
    end
    exp = {acc, rv, en[0], en[1], en[2], en[3], en[4],
           bub[1], bub[2], bub[3], bub[4]};
`ifdef PIPE_CTRL_PERF_EN
    ps = m_stall;
    pf = m_flush;
`else
    ps = '0;
    pf = '0;
`endif
    got = dut_vec();
    chk("ctrl_vec", {21'd0, got}, {21'd0, exp});
    chk("redirect_pc", redirect_pc, m_pc);
    chk("perf_stall", perf_stall_cnt, ps);
    chk("perf_flush", perf_flush_cnt, pf);
    @(posedge clk);
    if (!r) begin
      if (busy == 0 && |st) m_stall = m_stall + 1;
      if (acc) begin
        busy    = FC;
        first   = 1'b1;
        m_pc    = tg;
        m_flush = m_flush + 1;
      end else if (busy > 0) begin
        busy  = busy - 1;
        first = 1'b0;
      end
    end
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 32'h0);
  endtask

  initial begin
    model_reset();
    @(posedge clk);

    // reset state
    step(1, 0, 0, 0, 0, 0, 32'h0);
    chk("rst_vec", {21'd0, got}, {21'd0, 11'b00_11111_0000});
    step(1, 1, 1, 1, 1, 1, 32'h1234);
    chk("rst_inputs_masked", {21'd0, got},
        {21'd0, 11'b00_11111_0000});
    idle();

    // EX+ID stall for three cycles
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 1, 0, 0, 32'h0);
      chk("ex_stall", {21'd0, got}, {21'd0, 11'b00_00011_0010});
    end
    idle();

    // clean redirect
    step(0, 0, 0, 0, 0, 1, 32'hBFC00380);
    chk("ack_cycle", {21'd0, got}, {21'd0, 11'b10_11111_1111});
    idle();
    chk("first_flush", {21'd0, got}, {21'd0, 11'b01_11111_1110});
    chk("redirect_pc_lit", redirect_pc, 32'hBFC00380);
    idle();
    idle();
    chk("last_flush", {21'd0, got}, {21'd0, 11'b00_11111_1110});
    idle();
    chk("back_in_run", {21'd0, got}, {21'd0, 11'b00_11111_0000});

    // redirect held off by MEM stall
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 1, 1, 32'h8000_0180);
      chk("mem_stall_noack", {21'd0, got},
          {21'd0, 11'b00_00001_0001});
    end
    step(0, 0, 0, 0, 0, 1, 32'h8000_0180);
    chk("ack_after_mem", {21'd0, got}, {21'd0, 11'b10_11111_1111});

    // stalls and new request ignored during FLUSH
    for (int i = 0; i < FC; i++) begin
      step(0, 1, 0, 0, 0, 1, 32'h0000_0200);
      chk("flush_ignores_req", {31'd0, got[10]}, 32'd0);
    end
    step(0, 1, 0, 0, 0, 1, 32'h0000_0200);
    chk("second_ack", {21'd0, got}, {21'd0, 11'b10_11111_1111});
    for (int i = 0; i < FC; i++) idle();

    // reset during the second FLUSH cycle
    step(0, 0, 0, 0, 0, 1, 32'hDEAD_BEE0);
    idle();
    step(1, 0, 0, 0, 0, 0, 32'h0);
    chk("rst_mid_flush", {21'd0, got}, {21'd0, 11'b00_11111_0000});
    chk("rst_mid_flush_pc", redirect_pc, 32'h0);
    step(1, 0, 0, 0, 0, 0, 32'h0);
    idle();
    chk("run_after_rst", {21'd0, got}, {21'd0, 11'b00_11111_0000});

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(99) == 0,
           $urandom_range(3) == 0,
           $urandom_range(3) == 0,
           $urandom_range(3) == 0,
           $urandom_range(3) == 0,
           $urandom_range(2) == 0,
           $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vec_n, err_n);
    $finish;
  end

endmodule
